pilot_remover: RTL and testbench

- Receive-side stage that directly consumes the transmitter's pilot-inserted sample stream (16-bit signed samples, one per start strobe).
- Acquires frame alignment by detecting a run of pilot samples, then strips pilots and forwards only payload samples with a one-cycle valid pulse.
- Continuously re-checks each pilot field; declares loss of lock and re-searches when pilots are corrupted.
- Feeds the carrier demodulator (I/Q down-mix) downstream.

---
 rtl/pilot_remover.sv | 156 +++++++++++++++
 tb/tb_pilot_remover.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pilot_remover.sv
// Strips pilot fields from a framed sample stream after acquiring alignment on a pilot run.
// Latency 1 clk strobe-to-output; no backpressure, advances only on start strobes.
module pilot_remover #(
    parameter int                            width_data  = 16,
    parameter int                            wid_count   = 4,
    parameter int                            PILOT_LEN   = 4,
    parameter int                            PAYLOAD_LEN = 12,
    parameter logic signed [width_data-1:0]  PILOT_WORD  = 16'sh4000,
    parameter logic        [width_data-1:0]  TOL         = 16'h0400,
    parameter int                            MAX_ERR     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [width_data-1:0] data_in,
    output logic [width_data-1:0] data_out,
    output logic                  ready,
    output logic                  frame_start,
    output logic                  locked,
    output logic                  lost_lock
);

    typedef enum logic [1:0] {SEARCH, PAYLOAD, PILOT_CHK} state_t;
    typedef logic [wid_count:0] cnt_t;

    localparam cnt_t PIL_LAST = cnt_t'(PILOT_LEN - 1);
    localparam cnt_t PAY_LAST = cnt_t'(PAYLOAD_LEN - 1);
    localparam cnt_t ERR_MAX  = cnt_t'(MAX_ERR);
    localparam cnt_t CNT_SAT  = '1;

    state_t                state_q, state_d;
    cnt_t                  run_cnt_q, run_cnt_d;
    cnt_t                  pay_cnt_q, pay_cnt_d;
    cnt_t                  pil_cnt_q, pil_cnt_d;
    cnt_t                  err_cnt_q, err_cnt_d;
    cnt_t                  err_nxt;
    logic [width_data-1:0] data_out_q, data_out_d;
    logic                  ready_q, ready_d;
    logic                  frame_start_q, frame_start_d;
    logic                  locked_q, locked_d;
    logic                  lost_lock_q, lost_lock_d;

    // One extra bit keeps both sign extremes from wrapping.
    logic signed [width_data:0] diff;
    logic        [width_data:0] mag;
    logic                       match;

    assign diff  = $signed({data_in[width_data-1], data_in})
                 - $signed({PILOT_WORD[width_data-1], PILOT_WORD});
    assign mag   = diff[width_data] ? $unsigned(-diff) : $unsigned(diff);
    assign match = (mag <= {1'b0, TOL});

    always_comb begin
        state_d       = state_q;
        run_cnt_d     = run_cnt_q;
        pay_cnt_d     = pay_cnt_q;
        pil_cnt_d     = pil_cnt_q;
        err_cnt_d     = err_cnt_q;
        data_out_d    = data_out_q;
        locked_d      = locked_q;
        ready_d       = 1'b0;
        frame_start_d = 1'b0;
        lost_lock_d   = 1'b0;
        err_nxt       = err_cnt_q;
        if (!match && err_cnt_q != CNT_SAT) begin
            err_nxt = err_cnt_q + cnt_t'(1);
        end

        if (start) begin
            case (state_q)
                SEARCH: begin
                    if (!match) begin
                        run_cnt_d = '0;
                    end else if (run_cnt_q == PIL_LAST) begin
                        run_cnt_d = '0;
                        pay_cnt_d = '0;
                        locked_d  = 1'b1;
                        state_d   = PAYLOAD;
                    end else begin
                        run_cnt_d = run_cnt_q + cnt_t'(1);
                    end
                end
                PAYLOAD: begin
                    data_out_d    = data_in;
                    ready_d       = 1'b1;
                    frame_start_d = (pay_cnt_q == '0);
                    if (pay_cnt_q == PAY_LAST) begin
                        pay_cnt_d = '0;
                        pil_cnt_d = '0;
                        err_cnt_d = '0;
                        state_d   = PILOT_CHK;
                    end else begin
                        pay_cnt_d = pay_cnt_q + cnt_t'(1);
                    end
                end
                PILOT_CHK: begin
                    // The last pilot of the field counts toward the verdict.
                    if (pil_cnt_q == PIL_LAST) begin
                        pil_cnt_d = '0;
                        err_cnt_d = '0;
                        if (err_nxt <= ERR_MAX) begin
                            pay_cnt_d = '0;
                            state_d   = PAYLOAD;
                        end else begin
                            run_cnt_d   = '0;
                            locked_d    = 1'b0;
                            lost_lock_d = 1'b1;
                            state_d     = SEARCH;
                        end
                    end else begin
                        pil_cnt_d = pil_cnt_q + cnt_t'(1);
                        err_cnt_d = err_nxt;
                    end
                end
                default: begin
                    run_cnt_d = '0;
                    locked_d  = 1'b0;
                    state_d   = SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SEARCH;
            run_cnt_q     <= '0;
            pay_cnt_q     <= '0;
            pil_cnt_q     <= '0;
            err_cnt_q     <= '0;
            data_out_q    <= '0;
            ready_q       <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            lost_lock_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            run_cnt_q     <= run_cnt_d;
            pay_cnt_q     <= pay_cnt_d;
            pil_cnt_q     <= pil_cnt_d;
            err_cnt_q     <= err_cnt_d;
            data_out_q    <= data_out_d;
            ready_q       <= ready_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            lost_lock_q   <= lost_lock_d;
        end
    end

    assign data_out    = data_out_q;
    assign ready       = ready_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign lost_lock   = lost_lock_q;

endmodule

// File: tb/tb_pilot_remover.sv
// Bench for pilot_remover: directed streams plus random framed traffic against a frame-position model.
module tb_pilot_remover;

    localparam int PIL   = 4;
    localparam int PAY   = 12;
    localparam int FRAME = PIL + PAY;
    localparam int MAXE  = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] data_in = '0;
    logic [15:0] data_out;
    logic        ready, frame_start, locked, lost_lock;

    pilot_remover dut (
        .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
        .data_out(data_out), .ready(ready), .frame_start(frame_start),
        .locked(locked), .lost_lock(lost_lock)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: alignment is a window of the last PIL strobes all being pilots;
    // once locked, frame position is simply strobes-since-lock mod FRAME.
    bit          m_locked;
    int          m_pos;
    int          m_ferr;
    bit          m_hist[$];
    logic [15:0] m_data;
    bit          m_ready, m_fs, m_lost;

    function automatic bit is_pilot(input logic [15:0] v);
        int d;
        d = int'($signed(v)) - 16384;
        if (d < 0) d = -d;
        return d <= 1024;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_pos = 0; m_ferr = 0; m_hist.delete();
        m_data = '0; m_ready = 0; m_fs = 0; m_lost = 0;
    endtask

    task automatic model_strobe(input logic [15:0] v);
        bit m;
        bit all;
        int p;
        m = is_pilot(v);
        m_ready = 0; m_fs = 0; m_lost = 0;
        if (!m_locked) begin
            m_hist.push_back(m);
            if (m_hist.size() > PIL) void'(m_hist.pop_front());
            all = (m_hist.size() == PIL);
            foreach (m_hist[i]) if (!m_hist[i]) all = 0;
            if (all) begin
                m_locked = 1; m_pos = 0; m_hist.delete();
            end
        end else begin
            p = m_pos % FRAME;
            if (p < PAY) begin
                m_ready = 1; m_data = v; m_fs = (p == 0);
            end else begin
                if (p == PAY) m_ferr = 0;
                if (!m) m_ferr++;
                if (p == FRAME - 1 && m_ferr > MAXE) begin
                    m_locked = 0; m_lost = 1; m_hist.delete();
                end
            end
            m_pos++;
        end
    endtask

    task automatic cycle(input bit st, input logic [15:0] v);
        @(negedge clk);
        start   = st;
        data_in = st ? v : 16'($urandom);
        @(posedge clk);
        #1;
        if (st) model_strobe(v);
        else begin m_ready = 0; m_fs = 0; m_lost = 0; end
        chk("ready", 32'(ready), 32'(m_ready));
        chk("frame_start", 32'(frame_start), 32'(m_fs));
        chk("locked", 32'(locked), 32'(m_locked));
        chk("lost_lock", 32'(lost_lock), 32'(m_lost));
        chk("data_out", 32'(data_out), 32'(m_data));
    endtask

    task automatic send(input logic [15:0] v, input int gap);
        repeat (gap) cycle(1'b0, 16'h0);
        cycle(1'b1, v);
    endtask

    task automatic clean_frames(input int n, input int gap);
        for (int f = 0; f < n; f++) begin
            repeat (PIL) send(16'h4000, gap);
            for (int k = 1; k <= PAY; k++) send(16'(k), gap);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_data_out"}, 32'(data_out), 32'h0);
        chk({tag, "_ready"}, 32'(ready), 32'h0);
        chk({tag, "_frame_start"}, 32'(frame_start), 32'h0);
        chk({tag, "_locked"}, 32'(locked), 32'h0);
        chk({tag, "_lost_lock"}, 32'(lost_lock), 32'h0);
    endtask

    function automatic logic [15:0] pilot_val();
        int off;
        case ($urandom_range(0, 9))
            0: off = 1024;
            1: off = -1024;
            2: off = 1025;
            3: off = -1025;
            4: return 16'($urandom);
            default: off = int'($urandom_range(0, 2048)) - 1024;
        endcase
        return 16'(16384 + off);
    endfunction

    logic [15:0] fs_seq[7];
    logic [15:0] ext_seq[9];

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        clean_frames(3, 0);

        // Pilot field with one error keeps lock; next field with two drops it.
        send(16'h4000, 0); send(16'h0000, 0); send(16'h4000, 0); send(16'h4000, 0);
        for (int k = 1; k <= PAY; k++) send(16'(k), 0);
        send(16'h4000, 0); send(16'h0000, 0); send(16'h0000, 0); send(16'h4000, 0);
        for (int k = 1; k <= 5; k++) send(16'(k), 0);

        fs_seq = '{16'h4000, 16'h4000, 16'h0000, 16'h43FF, 16'h43FF, 16'h43FF, 16'h43FF};
        foreach (fs_seq[i]) send(fs_seq[i], 0);
        send(16'h8000, 0); send(16'h7FFF, 0);
        for (int k = 1; k <= PAY - 2; k++) send(16'(k), 0);
        send(16'h8000, 0); send(16'h7FFF, 0); send(16'h4401, 0); send(16'h4000, 0);

        ext_seq = '{16'h4000, 16'h4000, 16'h4000, 16'h4401, 16'h8000, 16'h7FFF,
                    16'h3C00, 16'h4400, 16'h4000};
        foreach (ext_seq[i]) send(ext_seq[i], 0);
        send(16'h4000, 0);
        for (int k = 1; k <= 5; k++) send(16'(k), 0);

        // Asynchronous reset mid-payload.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        clean_frames(3, 2);

        for (int f = 0; f < 60; f++) begin
            int g;
            g = $urandom_range(0, 2);
            if ($urandom_range(0, 7) == 0) send(16'($urandom), 0);
            repeat (PIL) send(pilot_val(), (g == 0) ? 0 : int'($urandom_range(0, g)));
            repeat (PAY) send(16'($urandom), (g == 0) ? 0 : int'($urandom_range(0, g)));
        end

        repeat (3) cycle(1'b0, 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
